spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  Initiator end of the team's 16-bit SPI link, mode 0, MSB first.
//  Turns a parallel request into one SSB-framed packet: {rw, addr[6:0], data[7:0]}.
//   - rw=1 is a read; rw=0 is a write.
//  Generates SCLK from the system clock, drives MOSI and samples MISO.
//  Sits between a host register/command engine and the off-block SPI slave.
// PARAMETERS
//  PKTSZ    16  total bits per packet
//  HEADER    8  header bits: rw + address
//  PAYLOAD   8  data bits
//  ADDRSZ    7  address width
//  CLKDIV    4  SCLK half-period in clk cycles
//    - minimum 4: the slave triple-syncs SCLK/SSB
//    - elaboration assertion enforces the minimum
// PORTS
//  clk      in   1        system clock
//  reset_n  in   1        asynchronous active-low reset
//  start    in   1        request strobe; accepted only when busy=0
//  rw_in    in   1        1=read, 0=write; captured with start
//  addr_in  in   ADDRSZ   target address; captured with start
//  tx_d     in   PAYLOAD  write data; captured with start, ignored on reads
//  busy     out  1        high from the cycle after an accepted start to return to IDLE
//  done     out  1        one-cycle pulse at end of every packet
//  rx_d     out  PAYLOAD  read data; held until the next read completes
//  rxdv     out  1        one-cycle pulse with done, reads only
//  SCLK     out  1        serial clock, idle low
//  SSB      out  1        active-low slave select, idle high
//  MOSI     out  1        serial out
//  MISO     in   1        serial in, asynchronous
// BEHAVIOUR
//  Reset (async, immediate):
//   - SSB=1, SCLK=0, MOSI=0, busy=0, done=0, rxdv=0, rx_d=0, state=IDLE
//   - reset mid-packet aborts with no done
//  FSM states: IDLE -> SETUP -> LOW <-> HIGH -> HOLD -> GAP -> IDLE
//   - IDLE: start=1 loads shreg={rw_in,addr_in,(rw_in ? 0 : tx_d)}, bitcnt=0
//     - SSB falls on that edge; MOSI=shreg[15]; next state SETUP
//     - start while busy=1 is ignored, no queueing
//   - SETUP: CLKDIV cycles, SCLK low (SSB-to-first-edge setup)
//   - HIGH: SCLK=1 for CLKDIV cycles; slave samples MOSI on the rising edge
//     - last HIGH cycle: if rw and bitcnt>=HEADER, rx shift <= {rx shift, miso_s}
//     - miso_s is MISO through a 2-flop synchronizer
//     - exit: if bitcnt==PKTSZ-1 go HOLD, else bitcnt++ and go LOW
//   - LOW: SCLK=0 for CLKDIV cycles
//     - on entry (falling edge) shreg shifts left; MOSI=new shreg[15]
//   - HOLD: CLKDIV cycles, SCLK low, SSB low
//   - GAP: SSB=1 from entry, MOSI=0, CLKDIV cycles, then IDLE
//     - entry cycle: done=1; for reads rx_d<=rx shift and rxdv=1
//  Timing:
//   - SCLK period 2*CLKDIV; exactly PKTSZ rising edges per packet
//   - busy lasts (2*PKTSZ+3)*CLKDIV cycles = 140 at CLKDIV=4
//  Widths: bitcnt $clog2(PKTSZ) bits, no wrap inside a packet; div counter $clog2(CLKDIV) bits
//  All outputs are registered: no combinational path start->SCLK/SSB/MOSI
// STRUCTURE
//  Package spi_pkg:
//   - PKTSZ/HEADER/PAYLOAD/ADDRSZ constants
//   - spi_mst_state_t enum
//   - spi_pkt_t packed struct {rw, addr, data}
//   - shared with spi_slave benches
//  One sub-module, spi_sclk_gen:
//   - CLKDIV phase counter with enable
//   - emits phase_end strobe; FSM owns SCLK level
// TESTING
//  1 Write rw=0 addr=0x2A tx_d=0xA5 -> MOSI at 16 rising edges = 0,0101010,10100101; done once; rxdv=0
//  2 Read addr=0x11, slave model drives 0x3C in bits 8-15 -> rx_d=0x3C, rxdv and done pulse together
//  3 start re-pulsed while busy, mid-packet -> ignored; exactly 16 SCLK edges; next start after IDLE accepted
//  4 reset_n low at bit 5 -> same-time SSB=1/SCLK=0/busy=0, no done; follow-up write completes correctly
//  5 CLKDIV=4 and 7 -> SCLK high/low exactly CLKDIV cycles; busy = 140 / 245 cycles; SSB setup/hold = CLKDIV
//  6 Loopback with spi_slave: write 0x5A to addr 0x03 -> slave rx_d=0x5A, addr=0x03, rxdv pulses

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link definitions.
// Packet layout, widths and initiator FSM states.
package spi_pkg;

   localparam int PKTSZ   = 16;
   localparam int HEADER  = 8;
   localparam int PAYLOAD = 8;
   localparam int ADDRSZ  = 7;
   localparam int CNTW    = $clog2(PKTSZ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOW,
      S_HIGH,
      S_HOLD,
      S_GAP
   } spi_mst_state_t;

   typedef struct packed {
      logic               rw;
      logic [ADDRSZ-1:0]  addr;
      logic [PAYLOAD-1:0] data;
   } spi_pkt_t;

   // Reads go out with an all-zero data field.
   function automatic spi_pkt_t spi_pack(
      input logic               rw,
      input logic [ADDRSZ-1:0]  addr,
      input logic [PAYLOAD-1:0] data
   );
      spi_pkt_t p;
      p.rw   = rw;
      p.addr = addr;
      p.data = rw ? '0 : data;
      return p;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase timer for the SPI initiator.
// Strobes phase_end on the last clk of every CLKDIV-long phase.
module spi_sclk_gen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic phase_end
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] TERM = DW'(CLKDIV - 1);

   logic [DW-1:0] cnt;

   // The slave triple-syncs SCLK/SSB, so shorter phases are unsafe.
   if (CLKDIV < 4) begin : g_div_chk
      $error("spi_sclk_gen: CLKDIV must be at least 4");
   end

   assign phase_end = en && (cnt == TERM);

   // Phase counter restarts on every phase boundary and while idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!en || phase_end)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/spi_master.sv
// SPI initiator, mode 0, MSB first, 16-bit packets.
// Frames {rw, addr, data} under SSB; every output is a flop.
import spi_pkg::*;

module spi_master #(
   parameter int CLKDIV = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               rw_in,
   input  logic [ADDRSZ-1:0]  addr_in,
   input  logic [PAYLOAD-1:0] tx_d,
   output logic               busy,
   output logic               done,
   output logic [PAYLOAD-1:0] rx_d,
   output logic               rxdv,
   output logic               SCLK,
   output logic               SSB,
   output logic               MOSI,
   input  logic               MISO
);

   localparam logic [CNTW-1:0] LASTBIT = CNTW'(PKTSZ - 1);
   localparam logic [CNTW-1:0] HDRBIT  = CNTW'(HEADER);

   spi_mst_state_t     state, state_n;
   logic [PKTSZ-1:0]   shreg, shreg_n;
   logic [CNTW-1:0]    bitcnt, bitcnt_n;
   logic [PAYLOAD-1:0] rxsh, rxsh_n;
   logic [PAYLOAD-1:0] rxd_n;
   logic               rw_q, rw_n;
   logic               sclk_n, ssb_n;
   logic               busy_n, done_n, rxdv_n;
   logic               miso_m, miso_s;
   logic               phase_end;
   spi_pkt_t           pkt;

   spi_sclk_gen #(
      .CLKDIV    (CLKDIV)
   ) u_sclk_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (state != S_IDLE),
      .phase_end (phase_end)
   );

   // MOSI is the shift register MSB, cleared outside a packet.
   assign MOSI = shreg[PKTSZ-1];

   // Two-flop synchronizer for the asynchronous MISO pin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         miso_m <= 1'b0;
         miso_s <= 1'b0;
      end else begin
         miso_m <= MISO;
         miso_s <= miso_m;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         shreg  <= '0;
         bitcnt <= '0;
         rxsh   <= '0;
         rw_q   <= 1'b0;
         SCLK   <= 1'b0;
         SSB    <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         rxdv   <= 1'b0;
         rx_d   <= '0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         bitcnt <= bitcnt_n;
         rxsh   <= rxsh_n;
         rw_q   <= rw_n;
         SCLK   <= sclk_n;
         SSB    <= ssb_n;
         busy   <= busy_n;
         done   <= done_n;
         rxdv   <= rxdv_n;
         rx_d   <= rxd_n;
      end
   end

   // Next-state and next-output decode; pulses default low.
   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      rxsh_n   = rxsh;
      rw_n     = rw_q;
      sclk_n   = SCLK;
      ssb_n    = SSB;
      busy_n   = busy;
      done_n   = 1'b0;
      rxdv_n   = 1'b0;
      rxd_n    = rx_d;
      pkt      = spi_pack(rw_in, addr_in, tx_d);

      unique case (state)
         S_IDLE: begin
            if (start) begin
               shreg_n  = pkt;
               bitcnt_n = '0;
               rxsh_n   = '0;
               rw_n     = rw_in;
               ssb_n    = 1'b0;
               busy_n   = 1'b1;
               state_n  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (phase_end)
               state_n = S_LOW;
         end
         S_LOW: begin
            if (phase_end) begin
               sclk_n  = 1'b1;
               state_n = S_HIGH;
            end
         end
         S_HIGH: begin
            if (phase_end) begin
               if (rw_q && (bitcnt >= HDRBIT))
                  rxsh_n = {rxsh[PAYLOAD-2:0], miso_s};
               sclk_n = 1'b0;
               if (bitcnt == LASTBIT) begin
                  state_n = S_HOLD;
               end else begin
                  bitcnt_n = bitcnt + 1'b1;
                  shreg_n  = {shreg[PKTSZ-2:0], 1'b0};
                  state_n  = S_LOW;
               end
            end
         end
         S_HOLD: begin
            if (phase_end) begin
               ssb_n   = 1'b1;
               shreg_n = '0;
               done_n  = 1'b1;
               if (rw_q) begin
                  rxd_n  = rxsh;
                  rxdv_n = 1'b1;
               end
               state_n = S_GAP;
            end
         end
         S_GAP: begin
            if (phase_end) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
